// File: rtl/elastic_stage_reg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | elastic_stage_reg                                                          |
// | Circular-queue pipeline stage with valid/ready input, stall/bubble/flush   |
// | control, occupancy output and a saturating discarded-entry counter.        |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module elastic_stage_reg #(
  parameter int               WIDTH          = 112,
  parameter int               DEPTH          = 2,
  parameter logic [WIDTH-1:0] BUBBLE_PAYLOAD = {WIDTH{1'b0}},
  parameter int               DROP_W         = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid_i,
  output logic                       in_ready_o,
  input  logic [WIDTH-1:0]           in_payload_i,
  input  logic                       stall_i,
  input  logic                       bubble_i,
  input  logic                       flush_i,
  output logic                       out_valid_o,
  output logic [WIDTH-1:0]           out_payload_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o,
  output logic [DROP_W-1:0]          drop_cnt_o
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int SW = ((DROP_W > CW) ? DROP_W : CW) + 1;

  localparam logic [CW-1:0]     C_DEPTH    = CW'(DEPTH);
  localparam logic [PW-1:0]     C_LAST     = PW'(DEPTH - 1);
  localparam logic [DROP_W-1:0] C_DROP_MAX = {DROP_W{1'b1}};
  localparam logic [SW-1:0]     C_SUM_MAX  = SW'(C_DROP_MAX);

  logic [WIDTH-1:0]  r_mem [DEPTH];
  logic [PW-1:0]     r_rd_ptr;
  logic [PW-1:0]     r_wr_ptr;
  logic [CW-1:0]     r_count;
  logic [DROP_W-1:0] r_drop;

  logic              w_nonempty;
  logic              w_push;
  logic              w_pop;
  logic              w_kill;
  logic [SW-1:0]     w_drop_sum;
  logic [DROP_W-1:0] w_drop_flush;
  logic [DROP_W-1:0] w_drop_inc;
  logic [PW-1:0]     w_rd_next;
  logic [PW-1:0]     w_wr_next;

  assign w_nonempty = (r_count != '0);
  assign in_ready_o = !rst && !flush_i && (r_count < C_DEPTH);
  assign w_push     = in_valid_i && in_ready_o;
  // Any unstalled cycle with a head entry removes it: delivered or killed.
  assign w_pop      = w_nonempty && !flush_i && !stall_i;
  assign w_kill     = w_pop && bubble_i;

  assign w_rd_next  = (r_rd_ptr == C_LAST) ? '0 : r_rd_ptr + 1'b1;
  assign w_wr_next  = (r_wr_ptr == C_LAST) ? '0 : r_wr_ptr + 1'b1;

  // Flush add is done one bit wider than the counter, then clamped.
  assign w_drop_sum   = SW'(r_drop) + SW'(r_count);
  assign w_drop_flush = (w_drop_sum > C_SUM_MAX) ? C_DROP_MAX : w_drop_sum[DROP_W-1:0];
  assign w_drop_inc   = (r_drop == C_DROP_MAX) ? r_drop : r_drop + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
      r_drop   <= '0;
    end else if (flush_i) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
      r_drop   <= w_drop_flush;
    end else begin
      if (w_push) begin
        r_wr_ptr <= w_wr_next;
      end
      if (w_pop) begin
        r_rd_ptr <= w_rd_next;
      end
      if (w_kill) begin
        r_drop <= w_drop_inc;
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + 1'b1;
      end else if (!w_push && w_pop) begin
        r_count <= r_count - 1'b1;
      end
    end
  end

  // Storage needs no reset; entries are only visible through the count.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= in_payload_i;
    end
  end

  assign out_valid_o   = w_nonempty;
  assign out_payload_o = w_nonempty ? r_mem[r_rd_ptr] : BUBBLE_PAYLOAD;
  assign count_o       = r_count;
  assign drop_cnt_o    = r_drop;

endmodule
`default_nettype wire

// File: tb/tb_elastic_stage_reg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_elastic_stage_reg                                                       |
// | Two instances (DEPTH=2/DROP_W=16 and DEPTH=3/DROP_W=2) against a queue     |
// | reference model, directed scenarios followed by random traffic.            |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_elastic_stage_reg;

  localparam int              C_W      = 16;
  localparam logic [C_W-1:0]  C_BUB_A  = 16'hB0B0;
  localparam logic [C_W-1:0]  C_BUB_B  = 16'h0BAD;
  localparam int              C_DEP_A  = 2;
  localparam int              C_DEP_B  = 3;
  localparam int              C_MAX_A  = 65535;
  localparam int              C_MAX_B  = 3;

  logic           clk = 1'b0;
  logic           rst;
  logic           in_valid;
  logic [C_W-1:0] in_payload;
  logic           stall;
  logic           bubble;
  logic           flush;

  logic           ready_a, valid_a, ready_b, valid_b;
  logic [C_W-1:0] payload_a, payload_b;
  logic [1:0]     count_a, count_b;
  logic [15:0]    drop_a;
  logic [1:0]     drop_b;

  int n_cmp = 0;
  int n_err = 0;

  logic [C_W-1:0] q_a[$];
  logic [C_W-1:0] q_b[$];
  int             md_a, md_b;

  always #5 clk = ~clk;

  elastic_stage_reg #(
    .WIDTH(C_W), .DEPTH(C_DEP_A), .BUBBLE_PAYLOAD(C_BUB_A), .DROP_W(16)
  ) u_dut_a (
    .clk(clk), .rst(rst), .in_valid_i(in_valid), .in_ready_o(ready_a),
    .in_payload_i(in_payload), .stall_i(stall), .bubble_i(bubble), .flush_i(flush),
    .out_valid_o(valid_a), .out_payload_o(payload_a), .count_o(count_a),
    .drop_cnt_o(drop_a)
  );

  elastic_stage_reg #(
    .WIDTH(C_W), .DEPTH(C_DEP_B), .BUBBLE_PAYLOAD(C_BUB_B), .DROP_W(2)
  ) u_dut_b (
    .clk(clk), .rst(rst), .in_valid_i(in_valid), .in_ready_o(ready_b),
    .in_payload_i(in_payload), .stall_i(stall), .bubble_i(bubble), .flush_i(flush),
    .out_valid_o(valid_b), .out_payload_o(payload_b), .count_o(count_b),
    .drop_cnt_o(drop_b)
  );

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Queue semantics applied to the inputs seen at the clock edge.
  task automatic model_update(input int which);
    logic [C_W-1:0] q[$];
    int d, dmax, dep;
    bit acc;
    if (which == 0) begin q = q_a; d = md_a; dmax = C_MAX_A; dep = C_DEP_A; end
    else            begin q = q_b; d = md_b; dmax = C_MAX_B; dep = C_DEP_B; end
    if (rst) begin
      q.delete();
      d = 0;
    end else if (flush) begin
      d = d + q.size();
      if (d > dmax) d = dmax;
      q.delete();
    end else begin
      acc = in_valid && (q.size() < dep);
      if (!stall && q.size() > 0) begin
        if (bubble) begin
          d = d + 1;
          if (d > dmax) d = dmax;
        end
        void'(q.pop_front());
      end
      if (acc) q.push_back(in_payload);
    end
    if (which == 0) begin q_a = q; md_a = d; end
    else            begin q_b = q; md_b = d; end
  endtask

  task automatic check_all();
    logic [C_W-1:0] exp_a, exp_b;
    exp_a = C_BUB_A;
    exp_b = C_BUB_B;
    if (q_a.size() > 0) exp_a = q_a[0];
    if (q_b.size() > 0) exp_b = q_b[0];
    check_eq("a_valid",   64'(valid_a),   64'(q_a.size() != 0));
    check_eq("a_payload", 64'(payload_a), 64'(exp_a));
    check_eq("a_count",   64'(count_a),   64'(q_a.size()));
    check_eq("a_drop",    64'(drop_a),    64'(md_a));
    check_eq("a_ready",   64'(ready_a),   64'(!rst && !flush && q_a.size() < C_DEP_A));
    check_eq("b_valid",   64'(valid_b),   64'(q_b.size() != 0));
    check_eq("b_payload", 64'(payload_b), 64'(exp_b));
    check_eq("b_count",   64'(count_b),   64'(q_b.size()));
    check_eq("b_drop",    64'(drop_b),    64'(md_b));
    check_eq("b_ready",   64'(ready_b),   64'(!rst && !flush && q_b.size() < C_DEP_B));
  endtask

  task automatic tick();
    @(posedge clk);
    model_update(0);
    model_update(1);
    @(negedge clk);
    check_all();
  endtask

  initial begin
    md_a = 0; md_b = 0;
    rst = 1'b1; in_valid = 1'b1; in_payload = 16'h1111;
    stall = 1'b0; bubble = 1'b0; flush = 1'b0;

    // Reset held two cycles with a word offered.
    tick(); tick();
    check_eq("rst_count", 64'(count_a), 64'd0);
    check_eq("rst_ready", 64'(ready_a), 64'd0);
    check_eq("rst_payload", 64'(payload_b), 64'(C_BUB_B));

    // Fill with stall, then drain in order.
    rst = 1'b0; stall = 1'b1; in_payload = 16'h000A; tick();
    in_payload = 16'h000B; tick();
    check_eq("fill_count", 64'(count_a), 64'd2);
    check_eq("fill_ready", 64'(ready_a), 64'd0);
    in_payload = 16'h000C; tick();
    check_eq("held_count", 64'(count_a), 64'd2);
    stall = 1'b0; tick();
    check_eq("drain_head", 64'(payload_a), 64'h000B);
    tick();
    in_valid = 1'b0; tick(); tick(); tick();

    rst = 1'b1; tick(); rst = 1'b0;

    // Stall beats bubble.
    stall = 1'b1; in_valid = 1'b1; in_payload = 16'h0005; tick();
    in_payload = 16'h0006; tick();
    in_valid = 1'b0; bubble = 1'b1;
    repeat (3) tick();
    check_eq("sb_head", 64'(payload_a), 64'h0005);
    check_eq("sb_drop", 64'(drop_a), 64'd0);
    stall = 1'b0; tick();
    bubble = 1'b0;
    check_eq("bub_drop", 64'(drop_a), 64'd1);
    check_eq("bub_head", 64'(payload_a), 64'h0006);

    // Flush with a concurrent push offered.
    stall = 1'b1; in_valid = 1'b1; in_payload = 16'h0007; tick();
    in_payload = 16'h0008; flush = 1'b1;
    #1;
    check_eq("flush_ready", 64'(ready_a), 64'd0);
    tick();
    flush = 1'b0; in_valid = 1'b0; stall = 1'b0;
    check_eq("flush_count", 64'(count_a), 64'd0);
    check_eq("flush_drop", 64'(drop_a), 64'd3);
    tick();

    // Pointer wrap and drop-counter saturation.
    rst = 1'b1; tick(); rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1; in_payload = 16'(16'h0100 + i); tick();
    end
    in_valid = 1'b0; repeat (3) tick();
    stall = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_payload = 16'(16'h0200 + i); tick();
    end
    stall = 1'b0; bubble = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_payload = 16'(16'h0300 + i); tick();
    end
    bubble = 1'b0; in_valid = 1'b0;
    check_eq("sat_drop", 64'(drop_b), 64'd3);
    tick();

    // Random traffic.
    for (int i = 0; i < 2000; i++) begin
      rst        = ($urandom_range(0, 149) == 0);
      flush      = ($urandom_range(0, 39) == 0);
      stall      = ($urandom_range(0, 3) == 0);
      bubble     = ($urandom_range(0, 5) == 0);
      in_valid   = ($urandom_range(0, 2) != 0);
      in_payload = 16'($urandom);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
